// File: rtl/seq_divider_10by5.sv
`default_nettype none
// ============================================================================
// Module   : seq_divider_10by5
// Purpose  : Restoring unsigned divider, one quotient bit per clock,
//            valid/ready handshake on both sides.
// Options  : SEQ_DIVIDER_DBZ_EARLY_EN - zero divisor bypasses the iteration
//            and reports dbz=1 one cycle after accept.
// Revision : 1.0 - initial release
// ============================================================================
module seq_divider_10by5 #(
    parameter int DIVIDEND_W = 10,
    parameter int DIVISOR_W  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  dbz
);

    localparam int                 c_CNT_W = $clog2(DIVIDEND_W);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(DIVIDEND_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [DIVIDEND_W-1:0]   r_dq;        // dividend shifts out the top, quotient bits shift in
    logic [DIVISOR_W-1:0]    r_divisor;
    logic [DIVISOR_W:0]      r_prem;
    logic [c_CNT_W-1:0]      r_cnt;
    logic                    w_accept;
    logic                    w_last;
    logic [DIVISOR_W+1:0]    w_shift;
    logic [DIVISOR_W:0]      w_diff;
    logic                    w_qbit;
    logic [DIVISOR_W:0]      w_prem_next;

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign w_accept  = in_valid && (r_state == S_IDLE);
    assign w_last    = (r_cnt == c_LAST);

    // Comparison uses the full shifted value; the difference only matters when it fits.
    assign w_shift     = {r_prem, r_dq[DIVIDEND_W-1]};
    assign w_qbit      = (w_shift >= {2'b00, r_divisor});
    assign w_diff      = w_shift[DIVISOR_W:0] - {1'b0, r_divisor};
    assign w_prem_next = w_qbit ? w_diff : w_shift[DIVISOR_W:0];

`ifdef SEQ_DIVIDER_DBZ_EARLY_EN
    logic w_div_zero;
    logic r_dbz;
    assign w_div_zero = (divisor == '0);
    assign dbz        = r_dbz;
`else
    assign dbz = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
`ifdef SEQ_DIVIDER_DBZ_EARLY_EN
                    w_next_state = w_div_zero ? S_DONE : S_RUN;
`else
                    w_next_state = S_RUN;
`endif
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dq      <= '0;
            r_divisor <= '0;
            r_prem    <= '0;
            r_cnt     <= '0;
            quotient  <= '0;
            remainder <= '0;
`ifdef SEQ_DIVIDER_DBZ_EARLY_EN
            r_dbz     <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_dq      <= dividend;
                        r_divisor <= divisor;
                        r_prem    <= '0;
                        r_cnt     <= '0;
`ifdef SEQ_DIVIDER_DBZ_EARLY_EN
                        if (w_div_zero) begin
                            quotient  <= '1;
                            remainder <= dividend[DIVISOR_W-1:0];
                            r_dbz     <= 1'b1;
                        end
`endif
                    end
                end
                S_RUN: begin
                    r_dq   <= {r_dq[DIVIDEND_W-2:0], w_qbit};
                    r_prem <= w_prem_next;
                    r_cnt  <= r_cnt + 1'b1;
                    if (w_last) begin
                        quotient  <= {r_dq[DIVIDEND_W-2:0], w_qbit};
                        remainder <= w_prem_next[DIVISOR_W-1:0];
`ifdef SEQ_DIVIDER_DBZ_EARLY_EN
                        r_dbz     <= 1'b0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_divider_10by5.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_divider_10by5
// Purpose  : Directed scoreboard bench for seq_divider_10by5.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_divider_10by5;

`ifdef SEQ_DIVIDER_DBZ_EARLY_EN
    // Edges from accept to out_valid; early zero-divisor result is up right after the accept edge.
    localparam int c_DBZ_LAT  = 0;
    localparam int c_DBZ_FLAG = 1;
`else
    localparam int c_DBZ_LAT  = 10;
    localparam int c_DBZ_FLAG = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [9:0] dividend;
    logic [4:0] divisor;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] quotient;
    logic [4:0] remainder;
    logic       dbz;

    seq_divider_10by5 #(.DIVIDEND_W(10), .DIVISOR_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .dbz       (dbz)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] q;
        logic [4:0] r;
        logic       d;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc      = 0;
    int   accept_cyc = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: latency on out_valid rise, stability while held, scoreboard pop on handshake.
    initial begin
        logic       prev_ov = 1'b0;
        logic       post_hs = 1'b0;
        logic [9:0] hq = '0;
        logic [4:0] hr = '0;
        logic       hd = 1'b0;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_ov = 1'b0;
                post_hs = 1'b0;
            end else begin
                if (post_hs) begin
                    chk("ready_after_hs", int'(in_ready), 1);
                    chk("valid_after_hs", int'(out_valid), 0);
                    post_hs = 1'b0;
                end
                if (out_valid && !prev_ov) begin
                    if (sb.size() == 0) chk("unexpected_out_valid", 1, 0);
                    else                chk("latency", cyc - accept_cyc, sb[0].lat);
                    hq = quotient;
                    hr = remainder;
                    hd = dbz;
                end else if (out_valid) begin
                    chk("hold_quotient", int'(quotient), int'(hq));
                    chk("hold_remainder", int'(remainder), int'(hr));
                    chk("hold_dbz", int'(dbz), int'(hd));
                    chk("in_ready_in_done", int'(in_ready), 0);
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        chk("handshake_without_expect", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("quotient", int'(quotient), int'(e.q));
                        chk("remainder", int'(remainder), int'(e.r));
                        chk("dbz", int'(dbz), int'(e.d));
                    end
                    post_hs = 1'b1;
                end
                prev_ov = out_valid;
            end
        end
    end

    task automatic send(input int a, input int b, input int eq, input int er,
                        input int ed, input int el, input bit push);
        exp_t e;
        int   t;
        if (push) begin
            e.q = 10'(eq); e.r = 5'(er); e.d = 1'(ed); e.lat = el;
            sb.push_back(e);
        end
        dividend = 10'(a);
        divisor  = 5'(b);
        in_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        accept_cyc = cyc;
        in_valid   = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", sb.size(), 0);
            sb.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int t;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_quotient", int'(quotient), 0);
        chk("rst_remainder", int'(remainder), 0);
        chk("rst_dbz", int'(dbz), 0);
        @(posedge clk);
        #1;

        send(1000, 7, 142, 6, 0, 10, 1'b1);  drain();
        send(1023, 31, 33, 0, 0, 10, 1'b1);  drain();
        send(5, 9, 0, 5, 0, 10, 1'b1);       drain();
        send(1023, 1, 1023, 0, 0, 10, 1'b1); drain();
        send(0, 17, 0, 0, 0, 10, 1'b1);      drain();
        send(429, 0, 1023, 13, c_DBZ_FLAG, c_DBZ_LAT, 1'b1); drain();

        // Backpressure: result held 5 cycles, a stray request meanwhile must be ignored.
        out_ready = 1'b0;
        send(1000, 7, 142, 6, 0, 10, 1'b1);
        t = 0;
        while (!out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("bp_out_valid_seen", int'(out_valid), 1);
        @(posedge clk);
        #1;
        dividend = 10'd500;
        divisor  = 5'd3;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
        drain();
        send(500, 3, 166, 2, 0, 10, 1'b1); drain();

        // Reset during the 4th iteration discards the in-flight division.
        send(1023, 31, 0, 0, 0, 0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrun_rst_in_ready", int'(in_ready), 1);
        chk("midrun_rst_out_valid", int'(out_valid), 0);
        chk("midrun_rst_quotient", int'(quotient), 0);
        chk("midrun_rst_remainder", int'(remainder), 0);
        @(posedge clk);
        #1;
        send(100, 10, 10, 0, 0, 10, 1'b1); drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
